// File: rtl/mmio_responder_pkg.sv
// mmio_responder_pkg: register word indices and STATUS bit positions for the MMIO responder
package mmio_responder_pkg;
    localparam logic [5:0] ADDR_LED    = 6'h00;
    localparam logic [5:0] ADDR_SW     = 6'h01;
    localparam logic [5:0] ADDR_STATUS = 6'h02;
    localparam logic [5:0] ADDR_IN     = 6'h03;
    localparam logic [5:0] ADDR_OUT    = 6'h04;
    localparam logic [5:0] ADDR_TIMER  = 6'h05;
    localparam int ST_IN_VALID  = 0;
    localparam int ST_OUT_VALID = 1;
    localparam int ST_IN_OVR    = 2;
    localparam int ST_OUT_DROP  = 3;
endpackage

// File: rtl/mmio_responder_btn_debounce.sv
// mmio_responder_btn_debounce: 2-flop btn synchroniser plus debounce counter, emits a one-cycle press pulse
// Ports: clk, rst (sync, active-high), btn (async in), press (one-cycle pulse on debounced 0->1)
module mmio_responder_btn_debounce #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    logic             s1, s2, level;
    logic [CNT_W-1:0] cnt;
    logic             done;

    assign done  = (s2 != level) && (cnt == CNT_W'(DEB_CYCLES - 1));
    // Pulse coincides with the edge at which the debounced level rises.
    assign press = done && s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            level <= done ? s2 : level;
            cnt   <= (s2 == level || done) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: MMIO peripheral with LED, debounced switch capture, valid/ready output channel, status flags
// Ports: clk, rst (sync, active-high); io_addr/io_dout/io_we/io_rd/io_din CPU bus (io_din combinational);
//        sw/btn async inputs; led register; out_data/out_valid/out_ready output channel.
// Optional: define MMIO_TIMER_EN for a 32-bit free-running cycle counter at 0x14.
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  io_addr,
    input  logic [31:0] io_dout,
    input  logic        io_we,
    input  logic        io_rd,
    output logic [31:0] io_din,
    input  logic [7:0]  sw,
    input  logic        btn,
    output logic [7:0]  led,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    logic [5:0]  widx;
    logic [7:0]  sw_s1, sw_sync, in_data;
    logic        in_valid, in_ovr, out_drop, press;
    logic        wr_out, accept, rd_in, rd_st;
    logic [31:0] status, timer_rd;
    logic        unused_addr;

    assign widx        = io_addr[7:2];
    assign unused_addr = ^io_addr[1:0];
    assign wr_out      = io_we && widx == ADDR_OUT;
    assign accept      = wr_out && (!out_valid || out_ready);
    assign rd_in       = io_rd && widx == ADDR_IN;
    assign rd_st       = io_rd && widx == ADDR_STATUS;

    mmio_responder_btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .press (press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1     <= '0;
            sw_sync   <= '0;
            led       <= '0;
            in_data   <= '0;
            in_valid  <= 1'b0;
            in_ovr    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_drop  <= 1'b0;
        end else begin
            sw_s1     <= sw;
            sw_sync   <= sw_s1;
            led       <= (io_we && widx == ADDR_LED) ? io_dout[7:0] : led;
            in_data   <= press ? sw_sync : in_data;
            in_valid  <= press ? 1'b1 : (rd_in ? 1'b0 : in_valid);
            // Error events beat the clear-on-read of STATUS.
            in_ovr    <= (press && in_valid && !rd_in) || (in_ovr && !rd_st);
            out_drop  <= (wr_out && !accept) || (out_drop && !rd_st);
            out_data  <= accept ? io_dout : out_data;
            out_valid <= accept ? 1'b1 : (out_ready ? 1'b0 : out_valid);
        end
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] timer;
    always_ff @(posedge clk) begin
        if (rst) timer <= '0;
        else     timer <= (io_we && widx == ADDR_TIMER) ? io_dout : timer + 32'd1;
    end
    assign timer_rd = timer;
`else
    assign timer_rd = '0;
`endif

    always_comb begin
        status               = '0;
        status[ST_IN_VALID]  = in_valid;
        status[ST_OUT_VALID] = out_valid;
        status[ST_IN_OVR]    = in_ovr;
        status[ST_OUT_DROP]  = out_drop;
        io_din = widx == ADDR_LED    ? {24'd0, led}     :
                 widx == ADDR_SW     ? {24'd0, sw_sync} :
                 widx == ADDR_STATUS ? status           :
                 widx == ADDR_IN     ? {24'd0, in_data} :
                 widx == ADDR_OUT    ? out_data         :
                 widx == ADDR_TIMER  ? timer_rd         : 32'd0;
    end
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed table-driven bench for mmio_responder plus debounce/press sequences
module tb_mmio_responder;
    localparam int DEB = 16;
`ifdef MMIO_TIMER_EN
    localparam logic [31:0] TIMER_EXP = 32'h1;
`else
    localparam logic [31:0] TIMER_EXP = 32'h0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic [7:0]  io_addr = '0, sw = '0, led;
    logic [31:0] io_dout = '0, io_din, out_data;
    logic        io_we = 1'b0, io_rd = 1'b0, btn = 1'b0, out_valid, out_ready = 1'b0;
    int          total = 0, passed = 0;

    mmio_responder dut (
        .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
        .io_rd(io_rd), .io_din(io_din), .sw(sw), .btn(btn), .led(led),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] dout;
        logic        ready;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [7:0] a, input logic [31:0] exp, input string name);
        io_addr = a;
        #1;
        check(name, io_din, exp);
    endtask

    task automatic read_pulse(input logic [7:0] a);
        io_addr = a;
        io_rd = 1'b1;
        step();
        io_rd = 1'b0;
    endtask

    task automatic press(input int hold);
        btn = 1'b1;
        repeat (hold) step();
        btn = 1'b0;
        repeat (DEB + 4) step();
    endtask

    vec_t v[$];

    initial begin
        v = '{
            '{1, 0, 8'h00, 32'h000001A5, 0, 0, 32'h0},
            '{0, 1, 8'h00, 32'h0,        0, 1, 32'h000000A5},
            '{0, 0, 8'h03, 32'h0,        0, 1, 32'h000000A5},
            '{0, 0, 8'h04, 32'h0,        0, 1, 32'h0000003C},
            '{1, 0, 8'h04, 32'h000000FF, 0, 0, 32'h0},
            '{0, 0, 8'h04, 32'h0,        0, 1, 32'h0000003C},
            '{1, 0, 8'h20, 32'hFFFFFFFF, 0, 1, 32'h0},
            '{0, 0, 8'h18, 32'h0,        0, 1, 32'h0},
            '{1, 0, 8'h10, 32'hDEADBEEF, 0, 0, 32'h0},
            '{1, 0, 8'h10, 32'h12345678, 0, 1, 32'hDEADBEEF},
            '{0, 0, 8'h10, 32'h0,        0, 1, 32'hDEADBEEF},
            '{0, 0, 8'h08, 32'h0,        1, 1, 32'h0000000A},
            '{0, 1, 8'h08, 32'h0,        0, 1, 32'h00000008},
            '{0, 0, 8'h08, 32'h0,        0, 1, 32'h0},
            '{1, 0, 8'h10, 32'h00000011, 0, 0, 32'h0},
            '{1, 0, 8'h10, 32'h00000022, 1, 1, 32'h00000011},
            '{0, 0, 8'h10, 32'h0,        0, 1, 32'h00000022},
            '{0, 0, 8'h08, 32'h0,        0, 1, 32'h00000002},
            '{0, 0, 8'h08, 32'h0,        1, 1, 32'h00000002},
            '{0, 0, 8'h08, 32'h0,        0, 1, 32'h0},
            '{1, 0, 8'h14, 32'hFFFFFFFE, 0, 0, 32'h0},
            '{0, 0, 8'h00, 32'h0,        0, 0, 32'h0},
            '{0, 0, 8'h00, 32'h0,        0, 0, 32'h0},
            '{0, 0, 8'h00, 32'h0,        0, 0, 32'h0},
            '{0, 1, 8'h14, 32'h0,        0, 1, TIMER_EXP}
        };

        sw = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset led", {24'd0, led}, 32'h0);
        check("reset out_valid", {31'd0, out_valid}, 32'h0);
        check("reset out_data", out_data, 32'h0);
        peek(8'h08, 32'h0, "reset status");
        peek(8'h0C, 32'h0, "reset in_data");

        for (int i = 0; i < v.size(); i++) begin
            io_we = v[i].we;
            io_rd = v[i].rd;
            io_addr = v[i].addr;
            io_dout = v[i].dout;
            out_ready = v[i].ready;
            #1;
            if (v[i].chk) check($sformatf("vec%0d io_din", i), io_din, v[i].exp);
            step();
        end
        io_we = 1'b0;
        io_rd = 1'b0;
        out_ready = 1'b0;
        check("led port", {24'd0, led}, 32'hA5);
        check("out_data port", out_data, 32'h22);
        check("out_valid idle", {31'd0, out_valid}, 32'h0);

        press(DEB + 4);
        peek(8'h08, 32'h1, "press status");
        peek(8'h0C, 32'h3C, "press in_data");
        read_pulse(8'h0C);
        peek(8'h08, 32'h0, "status after in read");

        press(DEB + 4);
        sw = 8'h55;
        press(DEB + 4);
        peek(8'h08, 32'h5, "overrun status");
        peek(8'h0C, 32'h55, "overrun in_data");
        read_pulse(8'h08);
        peek(8'h08, 32'h1, "status after status read");
        read_pulse(8'h0C);
        peek(8'h08, 32'h0, "status cleared");

        press(DEB - 2);
        peek(8'h08, 32'h0, "glitch rejected");

        rst = 1'b1;
        io_we = 1'b1;
        io_addr = 8'h00;
        io_dout = 32'hFF;
        step();
        io_we = 1'b0;
        rst = 1'b0;
        check("rst beats write", {24'd0, led}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
